// File: rtl/xgmii_baser_dec_64_pkg.sv
// Shared 10GBASE-R / XGMII constants for the 64b/66b receive path.
// Holds XGMII characters, 7-bit control codes, O codes, sync headers and block types.
package xgmii_baser_dec_64_pkg;

    localparam logic [7:0] XGMII_IDLE   = 8'h07;
    localparam logic [7:0] XGMII_START  = 8'hFB;
    localparam logic [7:0] XGMII_TERM   = 8'hFD;
    localparam logic [7:0] XGMII_ERROR  = 8'hFE;
    localparam logic [7:0] XGMII_SEQ_OS = 8'h9C;
    localparam logic [7:0] XGMII_SIG_OS = 8'h5C;

    localparam logic [6:0] CTRL_IDLE  = 7'h00;
    localparam logic [6:0] CTRL_ERROR = 7'h1E;

    localparam logic [3:0] O_SEQ_OS = 4'h0;
    localparam logic [3:0] O_SIG_OS = 4'hF;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] BLOCK_TYPE_CTRL     = 8'h1E;
    localparam logic [7:0] BLOCK_TYPE_OS_4     = 8'h2D;
    localparam logic [7:0] BLOCK_TYPE_START_4  = 8'h33;
    localparam logic [7:0] BLOCK_TYPE_OS_START = 8'h66;
    localparam logic [7:0] BLOCK_TYPE_OS_04    = 8'h55;
    localparam logic [7:0] BLOCK_TYPE_START_0  = 8'h78;
    localparam logic [7:0] BLOCK_TYPE_OS_0     = 8'h4B;
    localparam logic [7:0] BLOCK_TYPE_TERM_0   = 8'h87;
    localparam logic [7:0] BLOCK_TYPE_TERM_1   = 8'h99;
    localparam logic [7:0] BLOCK_TYPE_TERM_2   = 8'hAA;
    localparam logic [7:0] BLOCK_TYPE_TERM_3   = 8'hB4;
    localparam logic [7:0] BLOCK_TYPE_TERM_4   = 8'hCC;
    localparam logic [7:0] BLOCK_TYPE_TERM_5   = 8'hD2;
    localparam logic [7:0] BLOCK_TYPE_TERM_6   = 8'hE1;
    localparam logic [7:0] BLOCK_TYPE_TERM_7   = 8'hFF;

    typedef enum logic [2:0] {
        BLK_DATA,
        BLK_START,
        BLK_TERM,
        BLK_IDLE,
        BLK_BAD
    } blk_class_t;

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } frame_state_t;

endpackage

// File: rtl/xgmii_baser_dec_64.sv
// 64b/66b block decoder to 64-bit XGMII with one cycle of latency.
// Ports: clk, rst (sync, active-high); encoded_rx_data/hdr in;
//        xgmii_rxd/rxc out; rx_bad_block, rx_sequence_error pulses.
module xgmii_baser_dec_64
    import xgmii_baser_dec_64_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] encoded_rx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
    output logic [DATA_WIDTH-1:0] xgmii_rxd,
    output logic [CTRL_WIDTH-1:0] xgmii_rxc,
    output logic                  rx_bad_block,
    output logic                  rx_sequence_error
);

    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $error("xgmii_baser_dec_64: DATA_WIDTH must be 64");
    end
    if (CTRL_WIDTH * 8 != DATA_WIDTH) begin : g_bad_ctrl_width
        $error("xgmii_baser_dec_64: CTRL_WIDTH*8 must equal DATA_WIDTH");
    end
    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $error("xgmii_baser_dec_64: HDR_WIDTH must be 2");
    end

    // {bad, character} for one 7-bit control code
    function automatic logic [8:0] ctrl_char(input logic [6:0] code);
        unique case (code)
            CTRL_IDLE:  ctrl_char = {1'b0, XGMII_IDLE};
            CTRL_ERROR: ctrl_char = {1'b0, XGMII_ERROR};
            default:    ctrl_char = {1'b1, XGMII_ERROR};
        endcase
    endfunction

    // {bad, character} for one 4-bit ordered-set code
    function automatic logic [8:0] os_char(input logic [3:0] code);
        unique case (code)
            O_SEQ_OS: os_char = {1'b0, XGMII_SEQ_OS};
            O_SIG_OS: os_char = {1'b0, XGMII_SIG_OS};
            default:  os_char = {1'b1, XGMII_ERROR};
        endcase
    endfunction

    // Lane holding T for a terminate block type, 8 if not a terminate
    function automatic int term_lane(input logic [7:0] t);
        unique case (t)
            BLOCK_TYPE_TERM_0: term_lane = 0;
            BLOCK_TYPE_TERM_1: term_lane = 1;
            BLOCK_TYPE_TERM_2: term_lane = 2;
            BLOCK_TYPE_TERM_3: term_lane = 3;
            BLOCK_TYPE_TERM_4: term_lane = 4;
            BLOCK_TYPE_TERM_5: term_lane = 5;
            BLOCK_TYPE_TERM_6: term_lane = 6;
            BLOCK_TYPE_TERM_7: term_lane = 7;
            default:           term_lane = 8;
        endcase
    endfunction

    logic [63:0]     d;
    logic [63:0]     dsh;
    logic [7:0][8:0] cl;
    logic [8:0]      o0;
    logic [8:0]      o4;
    int              term_k;
    logic [63:0]     dec_rxd;
    logic [7:0]      dec_rxc;
    logic            dec_bad;
    blk_class_t      cls;
    frame_state_t    state;
    frame_state_t    state_n;
    logic            seq_err_n;

    assign d = encoded_rx_data;
    // Terminate blocks pack data one byte up, behind the type field
    assign dsh = {8'h00, d[63:8]};

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cl[i] = ctrl_char(d[8 + 7 * i +: 7]);
        end
        o0 = os_char(d[35:32]);
        o4 = os_char(d[39:36]);
        term_k = term_lane(d[7:0]);
        dec_rxd = d;
        dec_rxc = 8'h00;
        dec_bad = 1'b0;
        cls = BLK_DATA;
        unique case (encoded_rx_hdr)
            SYNC_DATA: begin
                cls = BLK_DATA;
            end
            SYNC_CTRL: begin
                cls = BLK_IDLE;
                dec_rxc = 8'hFF;
                unique case (d[7:0])
                    BLOCK_TYPE_CTRL: begin
                        for (int i = 0; i < 8; i++) begin
                            dec_rxd[8 * i +: 8] = cl[i][7:0];
                            dec_bad = dec_bad | cl[i][8];
                        end
                    end
                    BLOCK_TYPE_START_0: begin
                        cls = BLK_START;
                        dec_rxd = {d[63:8], XGMII_START};
                        dec_rxc = 8'h01;
                    end
                    BLOCK_TYPE_START_4: begin
                        cls = BLK_START;
                        dec_rxd = {d[63:40], XGMII_START,
                                   cl[3][7:0], cl[2][7:0],
                                   cl[1][7:0], cl[0][7:0]};
                        dec_rxc = 8'h1F;
                        dec_bad = cl[0][8] | cl[1][8]
                                | cl[2][8] | cl[3][8];
                    end
                    BLOCK_TYPE_OS_START: begin
                        cls = BLK_START;
                        dec_rxd = {d[63:40], XGMII_START,
                                   d[31:8], o0[7:0]};
                        dec_rxc = 8'h11;
                        dec_bad = o0[8];
                    end
                    BLOCK_TYPE_OS_04: begin
                        dec_rxd = {d[63:40], o4[7:0],
                                   d[31:8], o0[7:0]};
                        dec_rxc = 8'h11;
                        dec_bad = o0[8] | o4[8];
                    end
                    BLOCK_TYPE_OS_0: begin
                        dec_rxd = {cl[7][7:0], cl[6][7:0],
                                   cl[5][7:0], cl[4][7:0],
                                   d[31:8], o0[7:0]};
                        dec_rxc = 8'hF1;
                        dec_bad = o0[8] | cl[4][8] | cl[5][8]
                                | cl[6][8] | cl[7][8];
                    end
                    BLOCK_TYPE_OS_4: begin
                        dec_rxd = {d[63:40], o4[7:0],
                                   cl[3][7:0], cl[2][7:0],
                                   cl[1][7:0], cl[0][7:0]};
                        dec_rxc = 8'h1F;
                        dec_bad = o4[8] | cl[0][8] | cl[1][8]
                                | cl[2][8] | cl[3][8];
                    end
                    default: begin
                        if (term_k < 8) begin
                            cls = BLK_TERM;
                            for (int i = 0; i < 8; i++) begin
                                if (i < term_k) begin
                                    dec_rxd[8 * i +: 8] = dsh[8 * i +: 8];
                                    dec_rxc[i] = 1'b0;
                                end else if (i == term_k) begin
                                    dec_rxd[8 * i +: 8] = XGMII_TERM;
                                end else begin
                                    dec_rxd[8 * i +: 8] = cl[i][7:0];
                                    dec_bad = dec_bad | cl[i][8];
                                end
                            end
                        end else begin
                            dec_bad = 1'b1;
                        end
                    end
                endcase
            end
            default: begin
                dec_bad = 1'b1;
            end
        endcase
        if (dec_bad) begin
            cls = BLK_BAD;
            dec_rxd = {8{XGMII_ERROR}};
            dec_rxc = 8'hFF;
        end
    end

    // Sequence checks use the flag before this block is applied
    always_comb begin
        state_n = state;
        seq_err_n = 1'b0;
        unique case (cls)
            BLK_DATA: begin
                seq_err_n = (state == ST_IDLE);
            end
            BLK_START: begin
                seq_err_n = (state == ST_FRAME);
                state_n = ST_FRAME;
            end
            BLK_TERM: begin
                seq_err_n = (state == ST_IDLE);
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            xgmii_rxd <= {8{XGMII_IDLE}};
            xgmii_rxc <= 8'hFF;
            rx_bad_block <= 1'b0;
            rx_sequence_error <= 1'b0;
        end else begin
            state <= state_n;
            xgmii_rxd <= dec_rxd;
            xgmii_rxc <= dec_rxc;
            rx_bad_block <= (cls == BLK_BAD);
            rx_sequence_error <= seq_err_n;
        end
    end

endmodule
